adder_8bit: RTL and testbench

//  - N-bit ripple add/sub datapath with carry/borrow in and out. Defaults to an 8-bit adder.
//  - Main result (diff, bout) is purely combinational; a registered copy is kept for pipelined consumers.
//  - Used as a generic arithmetic leaf inside generated datapaths.
//  - The port names diff/bout are shared with the subtract mode.

---
 rtl/adder_8bit_pkg.sv | 8 +
 rtl/adder_8bit_full_adder_cell.sv | 13 +
 rtl/adder_8bit.sv | 77 +++++++
 tb/tb_adder_8bit.sv | 146 ++++++++++++++
 4 files changed

// File: rtl/adder_8bit_pkg.sv
// Shared constants for the adder_8bit datapath leaf: operation mode encodings and default width.
package adder_pkg;

    localparam int unsigned MODE_ADD        = 0;
    localparam int unsigned MODE_SUB        = 1;
    localparam int unsigned ADDER_DEFAULT_N = 8;

endpackage

// File: rtl/adder_8bit_full_adder_cell.sv
// One-bit full adder; chained N times by adder_8bit to form the ripple carry path.
module full_adder_cell (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/adder_8bit.sv
// N-bit ripple add/sub with combinational result and a registered copy.
// Optional registered zero/overflow flags are enabled by defining ADDER_8BIT_FLAGS_EN.
module adder_8bit
    import adder_pkg::*;
#(
    parameter int unsigned N    = ADDER_DEFAULT_N,
    parameter int unsigned MODE = MODE_ADD
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         bin,
    output logic [N-1:0] diff,
    output logic         bout,
    output logic [N-1:0] diff_q,
    output logic         bout_q
`ifdef ADDER_8BIT_FLAGS_EN
    ,
    output logic         zero_q,
    output logic         ovf_q
`endif
);

    localparam bit SUB = (MODE == MODE_SUB);

    logic [N:0]   carry;
    logic [N-1:0] b_eff;

    // Subtract as a + ~b + ~bin; the borrow is then the inverted carry-out.
    assign b_eff    = SUB ? ~b : b;
    assign carry[0] = SUB ? ~bin : bin;

    for (genvar i = 0; i < N; i++) begin : g_cell
        full_adder_cell u_cell (
            .a    (a[i]),
            .b    (b_eff[i]),
            .cin  (carry[i]),
            .s    (diff[i]),
            .cout (carry[i+1])
        );
    end

    assign bout = SUB ? ~carry[N] : carry[N];

`ifdef ADDER_8BIT_FLAGS_EN
    logic zero;
    logic ovf;

    always_comb begin
        zero = (diff == '0);
        if (SUB)
            ovf = (a[N-1] != b[N-1]) && (diff[N-1] != a[N-1]);
        else
            ovf = (a[N-1] == b[N-1]) && (diff[N-1] != a[N-1]);
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            diff_q <= '0;
            bout_q <= 1'b0;
`ifdef ADDER_8BIT_FLAGS_EN
            zero_q <= 1'b0;
            ovf_q  <= 1'b0;
`endif
        end else begin
            diff_q <= diff;
            bout_q <= bout;
`ifdef ADDER_8BIT_FLAGS_EN
            zero_q <= zero;
            ovf_q  <= ovf;
`endif
        end
    end

endmodule

// File: tb/tb_adder_8bit.sv
// Self-checking bench for adder_8bit: one add and one subtract instance against an arithmetic reference.
module tb_adder_8bit;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] a;
    logic [7:0] b;
    logic       bin;

    logic [7:0] add_diff, add_diff_q, sub_diff, sub_diff_q;
    logic       add_bout, add_bout_q, sub_bout, sub_bout_q;
`ifdef ADDER_8BIT_FLAGS_EN
    logic       add_zero_q, add_ovf_q, sub_zero_q, sub_ovf_q;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    adder_8bit #(.N(8), .MODE(0)) u_add (
        .clk    (clk),
        .rst    (rst),
        .a      (a),
        .b      (b),
        .bin    (bin),
        .diff   (add_diff),
        .bout   (add_bout),
        .diff_q (add_diff_q),
        .bout_q (add_bout_q)
`ifdef ADDER_8BIT_FLAGS_EN
        ,
        .zero_q (add_zero_q),
        .ovf_q  (add_ovf_q)
`endif
    );

    adder_8bit #(.N(8), .MODE(1)) u_sub (
        .clk    (clk),
        .rst    (rst),
        .a      (a),
        .b      (b),
        .bin    (bin),
        .diff   (sub_diff),
        .bout   (sub_bout),
        .diff_q (sub_diff_q),
        .bout_q (sub_bout_q)
`ifdef ADDER_8BIT_FLAGS_EN
        ,
        .zero_q (sub_zero_q),
        .ovf_q  (sub_ovf_q)
`endif
    );

    task automatic check(input string tag, input logic [8:0] got, input logic [8:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // {carry, sum} of the full-precision integer sum
    function automatic logic [8:0] ref_add(input logic [7:0] x, input logic [7:0] y, input logic c);
        int s;
        s = int'(x) + int'(y) + int'(c);
        return 9'(s);
    endfunction

    // {borrow, difference mod 256}
    function automatic logic [8:0] ref_sub(input logic [7:0] x, input logic [7:0] y, input logic c);
        int d;
        logic [7:0] dm;
        logic br;
        d  = int'(x) - int'(y) - int'(c);
        dm = 8'(d);
        br = (int'(x) < int'(y) + int'(c));
        return {br, dm};
    endfunction

    // {7'b0, zero, ovf} from operand and result sign bits
    function automatic logic [8:0] ref_flags(input logic [7:0] x, input logic [7:0] y,
                                             input logic sub, input logic [7:0] d);
        logic z, o;
        z = (d == 8'd0);
        if (sub) o = (x[7] != y[7]) && (d[7] != x[7]);
        else     o = (x[7] == y[7]) && (d[7] != x[7]);
        return {7'd0, z, o};
    endfunction

    // Drive one vector at negedge, check combinational outputs, then registered outputs after the edge.
    task automatic apply(input string tag, input logic [7:0] x, input logic [7:0] y, input logic c,
                         input logic r);
        logic [8:0] ea, es;
        @(negedge clk);
        a = x; b = y; bin = c; rst = r;
        ea = ref_add(x, y, c);
        es = ref_sub(x, y, c);
        #2;
        check({tag, "_add_comb"}, {add_bout, add_diff}, ea);
        check({tag, "_sub_comb"}, {sub_bout, sub_diff}, es);
        @(posedge clk);
        #1;
        check({tag, "_add_q"}, {add_bout_q, add_diff_q}, r ? 9'd0 : ea);
        check({tag, "_sub_q"}, {sub_bout_q, sub_diff_q}, r ? 9'd0 : es);
`ifdef ADDER_8BIT_FLAGS_EN
        check({tag, "_add_flags"}, {7'd0, add_zero_q, add_ovf_q},
              r ? 9'd0 : ref_flags(x, y, 1'b0, ea[7:0]));
        check({tag, "_sub_flags"}, {7'd0, sub_zero_q, sub_ovf_q},
              r ? 9'd0 : ref_flags(x, y, 1'b1, es[7:0]));
`endif
    endtask

    initial begin
        rst = 1'b1; a = 8'h00; b = 8'h00; bin = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_add_q", {add_bout_q, add_diff_q}, 9'd0);
        check("rst_sub_q", {sub_bout_q, sub_diff_q}, 9'd0);

        apply("msb_carry",  8'h80, 8'h80, 1'b0, 1'b0);
        apply("ff_plus_1",  8'hFF, 8'h01, 1'b0, 1'b0);
        apply("h12_h34",    8'h12, 8'h34, 1'b1, 1'b0);
        apply("h05_h07",    8'h05, 8'h07, 1'b0, 1'b0);
        apply("h07_h05",    8'h07, 8'h05, 1'b1, 1'b0);
        apply("max_max_c1", 8'hFF, 8'hFF, 1'b1, 1'b0);
        apply("zero_c0",    8'h00, 8'h00, 1'b0, 1'b0);
        apply("zero_c1",    8'h00, 8'h00, 1'b1, 1'b0);
        apply("equal_c0",   8'h5A, 8'h5A, 1'b0, 1'b0);
        apply("ovf_7f",     8'h7F, 8'h01, 1'b0, 1'b0);
        apply("sub_ovf_80", 8'h80, 8'h01, 1'b0, 1'b0);

        // Reset asserted mid-stream: registers clear, combinational path unaffected
        apply("midrst",     8'hFF, 8'hFF, 1'b0, 1'b1);
        check("midrst_add_const", {add_bout, add_diff}, 9'h1FE);
        apply("post_rst",   8'h33, 8'h44, 1'b0, 1'b0);

        for (int i = 0; i < 200; i++) begin
            apply("rand", 8'($urandom), 8'($urandom), 1'($urandom), 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
